// File: rtl/seq_pkg.sv
// Shared types for the multicycle sequencer: FSM state encoding and width.
// Latency: n/a (types only).
// Backpressure: n/a.
package seq_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IF   = 3'd0,
    ST_ID   = 3'd1,
    ST_EX   = 3'd2,
    ST_MEM  = 3'd3,
    ST_WB   = 3'd4,
    ST_HALT = 3'd5
  } state_t;

endpackage

// File: rtl/mem_wait_timer.sv
// Counts MEM wait cycles after the request pulse and flags a timeout.
// Latency: timeout rises on the MEM_TIMEOUT-th cycle after start with no ready.
// Backpressure: none; inert (timeout stuck low) when MEM_TIMEOUT is 0.
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic clock,
  input  logic reset,
  input  logic start,
  input  logic ready,
  output logic timeout
);

  localparam int CW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam bit ENABLED = (MEM_TIMEOUT > 0);

  logic          running;
  logic [CW-1:0] count;

  // Start a wait window when the pulse goes out without an immediate ready;
  // count each further MEM cycle until ready or timeout ends the window.
  always_ff @(posedge clock) begin
    if (!reset) begin
      running <= 1'b0;
      count   <= '0;
    end else if (running) begin
      if (ready || timeout) begin
        running <= 1'b0;
        count   <= '0;
      end else begin
        count <= count + CW'(1);
      end
    end else if (start && !ready && ENABLED) begin
      running <= 1'b1;
      count   <= CW'(1);
    end
  end

  assign timeout = ENABLED && running && (count == CW'(MEM_TIMEOUT));

endmodule

// File: rtl/multicycle_sequencer.sv
// Multicycle MIPS control sequencer: IF/ID/EX/MEM/WB with one-cycle enables.
// Latency: 5 cycles per instruction (4 for non-memory ops with SEQ_SKIP_MEM_EN)
// plus MEM wait cycles; stalls in MEM until mem_ready or MEM_TIMEOUT expires.
module multicycle_sequencer
  import seq_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255,
  parameter int RETIRE_W    = 32
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                run,
  input  logic                dec_load,
  input  logic                dec_store,
  input  logic                dec_regwrite,
  input  logic                mem_ready,
  output logic [STATE_W-1:0]  state_out,
  output logic                ir_we,
  output logic                pc_we,
  output logic                rf_we,
  output logic                mem_re,
  output logic                mem_we,
  output logic                halted,
  output logic                mem_err,
  output logic [RETIRE_W-1:0] retired
);

  state_t state_q, state_d;
  logic   ld_q, st_q, rw_q;
  logic   ab_q;      // current access was aborted by timeout
  logic   wait_q;    // in MEM beyond its first cycle
  logic   access;
  logic   first_mem;
  logic   timeout;
  logic   set_err;
  logic   ir_c, pc_c, rf_c, re_c, we_c, halt_c;

  assign access    = ld_q | st_q;
  assign first_mem = (state_q == ST_MEM) && !wait_q;

  mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
    .clock   (clock),
    .reset   (reset),
    .start   (first_mem && access),
    .ready   (mem_ready),
    .timeout (timeout)
  );

  // Next-state and raw strobe decode; ready beats timeout in the same cycle.
  always_comb begin
    state_d = state_q;
    set_err = 1'b0;
    ir_c    = 1'b0;
    pc_c    = 1'b0;
    rf_c    = 1'b0;
    re_c    = 1'b0;
    we_c    = 1'b0;
    halt_c  = 1'b0;
    case (state_q)
      ST_IF: begin
        ir_c    = 1'b1;
        state_d = ST_ID;
      end
      ST_ID: state_d = ST_EX;
      ST_EX: begin
`ifdef SEQ_SKIP_MEM_EN
        state_d = access ? ST_MEM : ST_WB;
`else
        state_d = ST_MEM;
`endif
      end
      ST_MEM: begin
        if (!access) begin
          state_d = ST_WB;
        end else begin
          re_c = first_mem & ld_q;
          we_c = first_mem & st_q;
          if (mem_ready) begin
            state_d = ST_WB;
          end else if (timeout) begin
            state_d = ST_WB;
            set_err = 1'b1;
          end
        end
      end
      ST_WB: begin
        pc_c    = 1'b1;
        rf_c    = rw_q & ~(ab_q & ld_q);
        state_d = run ? ST_IF : ST_HALT;
      end
      ST_HALT: begin
        halt_c = 1'b1;
        if (run) state_d = ST_IF;
      end
      default: state_d = ST_IF;
    endcase
  end

  // State register, decode latches, abort/error flags and retire counter.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= ST_IF;
      ld_q    <= 1'b0;
      st_q    <= 1'b0;
      rw_q    <= 1'b0;
      ab_q    <= 1'b0;
      wait_q  <= 1'b0;
      mem_err <= 1'b0;
      retired <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= (state_q == ST_MEM) && (state_d == ST_MEM);
      if (state_q == ST_ID) begin
        ld_q <= dec_load;
        st_q <= dec_store;
        rw_q <= dec_regwrite;
        ab_q <= 1'b0;
      end else if (set_err) begin
        ab_q <= 1'b1;
      end
      if (set_err) mem_err <= 1'b1;
      if (state_q == ST_WB) retired <= retired + RETIRE_W'(1);
    end
  end

  // Strobes are gated by reset so a reset mid-access kills them immediately.
  assign state_out = reset ? state_q : ST_IF;
  assign ir_we     = reset & ir_c;
  assign pc_we     = reset & pc_c;
  assign rf_we     = reset & rf_c;
  assign mem_re    = reset & re_c;
  assign mem_we    = reset & we_c;
  assign halted    = reset & halt_c;

endmodule

// File: doc/multicycle_sequencer.md
# multicycle_sequencer

Multicycle control sequencer for the MIPS datapath. It steps each instruction through the phases IF, ID, EX, MEM and WB, and issues one-cycle write enables for the IR, PC and register file. It also issues single-pulse data-memory requests and stalls in MEM until the data memory (including serial IO) reports ready. It sits between the decoder/control_unit outputs and the datapath state elements, and replaces the single-cycle free-running PC update.

## Interface
Parameters:
- MEM_TIMEOUT, 255: maximum number of MEM wait cycles before abort; 0 disables the timeout.
- RETIRE_W, 32: width of the retired-instruction counter.

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low.
- run  in  1  when low, the sequencer completes the current instruction and parks in HALT.
- dec_load  in  1  decoded instruction is a load; valid from ID.
- dec_store  in  1  decoded instruction is a store; valid from ID.
- dec_regwrite  in  1  decoded instruction writes the register file; valid from ID.
- mem_ready  in  1  data memory has completed the outstanding request.
- state_out  out  3  current state: IF=0, ID=1, EX=2, MEM=3, WB=4, HALT=5.
- ir_we  out  1  IR capture enable.
- pc_we  out  1  PC update enable.
- rf_we  out  1  register-file write enable.
- mem_re  out  1  data-memory read request pulse.
- mem_we  out  1  data-memory write request pulse.
- halted  out  1  high while in HALT.
- mem_err  out  1  sticky; set on MEM timeout.
- retired  out  RETIRE_W  count of completed instructions; wraps modulo 2^RETIRE_W.

## Operation
- IF: ir_we=1. Next state is ID.
- ID:
  - Latch dec_load, dec_store and dec_regwrite into internal registers ld_q, st_q and rw_q.
  - Decoder inputs are ignored after ID.
  - Next state is EX.
- EX: no strobes. Next state is MEM for a load or store, otherwise see Configuration.
- MEM:
  - On the first MEM cycle only, mem_re=ld_q and mem_we=st_q; this gives exactly one pulse per access, so serial reads and writes are never duplicated.
  - mem_ready is sampled from the first MEM cycle onward. A ready in the same cycle as the pulse is legal and gives a single MEM cycle.
  - When ready is sampled high, next state is WB.
  - Wait counter: counts MEM cycles after the first. On reaching MEM_TIMEOUT with ready still low:
    - set mem_err;
    - mark the access aborted;
    - go to WB.
- WB:
  - pc_we=1.
  - rf_we = rw_q, except rf_we=0 for an aborted load.
  - retired increments.
  - Next state is IF if run=1, else HALT.
- HALT: all strobes 0 and halted=1. When run=1, next state is IF.
- run is sampled only in WB and HALT. Deasserting run mid-instruction never truncates the instruction.
- mem_err is cleared only by reset.

## Timing
- Reset values (while reset=0, and on the first cycle after release):
  - state=IF;
  - retired=0, mem_err=0, halted=0;
  - counter, ld_q, st_q and rw_q all 0.
- All strobes are combinational decodes of state gated by reset. A reset asserted mid-MEM drops mem_re/mem_we in that same cycle.
- The cycle after reset release is IF with ir_we=1.
- Latency:
  - ALU/branch/jump instructions: 5 cycles, or 4 with SKIP_MEM_EN.
  - Loads/stores: 5 cycles plus the number of cycles mem_ready is late.
  - Timeout case: 5+MEM_TIMEOUT cycles.
- Exactly one pc_we and one retired increment per instruction; no enable ever lasts more than one cycle.
- ready and timeout on the same cycle: ready wins; the access is not aborted and mem_err is unchanged.
- retired wraps from all-ones to 0 with no flag.

## Configuration
- SEQ_SKIP_MEM_EN defined: non-memory instructions go EX→WB directly, and MEM is entered only when ld_q|st_q.
- SEQ_SKIP_MEM_EN undefined: every instruction passes through MEM.
  - For non-memory instructions, MEM lasts exactly one cycle with no pulses and no dependence on mem_ready.
  - This keeps uniform 5-cycle timing for debug.

## Structure
- Shared package seq_pkg:
  - state type with the fixed encodings IF..HALT;
  - the width constant for state_out.
- One sub-module, mem_wait_timer:
  - inputs start and ready;
  - output timeout after MEM_TIMEOUT idle cycles;
  - inert when MEM_TIMEOUT=0.
- Top level holds the FSM, the ID latch registers, the mem_err flag and the retired counter.

## Test plan
- Reset release with run=1 and an ALU instruction: states 0,1,2,4,0 with SKIP_MEM_EN (0,1,2,3,4,0 without); pc_we and rf_we high in the WB cycle only; retired=1.
- Load with mem_ready arriving 3 cycles after the pulse: mem_re high in the first MEM cycle only; 4 MEM cycles; rf_we=1 in WB; total 8 cycles.
- Store with mem_ready tied high: single mem_we pulse; rf_we=0 in WB; 5 cycles.
- MEM_TIMEOUT=4, load with mem_ready held low: WB after 5 MEM cycles; mem_err=1 and stays set; rf_we=0; retired still increments.
- run dropped during EX: instruction completes through WB, then state=5 with halted=1. run reasserted: IF on the next cycle.
- reset pulled low during a MEM wait: mem_re/mem_we go to 0 the same cycle; after release state=0, retired=0, mem_err=0. Also preload retired to all-ones and retire one instruction → 0.
